// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: multi-line I2S / left-justified transmitter.
// NUM_LINES data pins share one lrclk. Each pin carries one stereo pair per frame of
// 2*SLOT_DW sclk periods. The block takes one frame of samples per handshake and sends
// all-zero samples when no data is ready (underrun). All state changes on the falling
// edge of sclk.
// Ports:
//   sclk         - bit clock (falling-edge active)
//   rst_n        - synchronous active-low reset
//   enable       - run request, sampled in IDLE and at the last frame cycle
//   mode         - 0 = Philips I2S (1-bit delay), 1 = left-justified; latched at load
//   in_valid     - in_data holds a frame
//   in_ready     - frame accepted on this edge when in_valid is also high
//   in_data      - line l, channel c at [(2*l+c)*AUDIO_DW +: AUDIO_DW]
//   lrclk        - 0 = left slot, 1 = right slot
//   sdata        - serial data per line, MSB first
//   underrun     - one-cycle pulse at cycle 0 of a frame loaded without data
//   underrun_cnt - saturating underrun count
module i2s_tx_multi #(
    parameter int unsigned AUDIO_DW  = 24,
    parameter int unsigned SLOT_DW   = 32,
    parameter int unsigned NUM_LINES = 2
) (
    input  logic                              sclk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              mode,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2*NUM_LINES*AUDIO_DW-1:0]   in_data,
    output logic                              lrclk,
    output logic [NUM_LINES-1:0]              sdata,
    output logic                              underrun,
    output logic [15:0]                       underrun_cnt
);

    if (AUDIO_DW < 1 || SLOT_DW < AUDIO_DW) begin : g_bad_params
        $error("i2s_tx_multi: need AUDIO_DW >= 1 and SLOT_DW >= AUDIO_DW");
    end

    localparam int unsigned CW = $clog2(2 * SLOT_DW);
    localparam int unsigned FW = 2 * NUM_LINES * AUDIO_DW;
    localparam logic [CW-1:0] LastCyc = CW'(2 * SLOT_DW - 1);
    localparam logic [CW-1:0] SlotLen = CW'(SLOT_DW);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FW-1:0]        frame_q, frame_d;
    logic                 mode_q, mode_d;
    logic [NUM_LINES-1:0] delay_q, delay_d;
    logic                 underrun_q, underrun_d;
    logic [15:0]          ucnt_q, ucnt_d;

    logic                 ch;
    logic [CW-1:0]        k;
    logic [NUM_LINES-1:0] lj_bit;

    // Channel and slot bit position of the current frame cycle.
    always_comb begin
        ch = (cnt_q >= SlotLen);
        k  = ch ? (cnt_q - SlotLen) : cnt_q;
    end

    // Left-justified bit of each line; shifting past AUDIO_DW yields the zero padding.
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        logic [AUDIO_DW-1:0] samp;
        logic [AUDIO_DW-1:0] shifted;
        assign samp      = ch ? frame_q[(2*l+1)*AUDIO_DW +: AUDIO_DW]
                              : frame_q[(2*l)*AUDIO_DW +: AUDIO_DW];
        assign shifted   = samp << k;
        assign lj_bit[l] = shifted[AUDIO_DW-1];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        mode_d     = mode_q;
        delay_d    = delay_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        in_ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Clearing the frame makes the dummy frame (and its I2S tail bit) zero.
                frame_d = '0;
                delay_d = '0;
                if (enable) begin
                    state_d = StRun;
                    cnt_d   = LastCyc;
                end
            end
            StRun: begin
                delay_d = lj_bit;
                if (cnt_q == LastCyc) begin
                    if (enable) begin
                        in_ready = 1'b1;
                        cnt_d    = '0;
                        mode_d   = mode;
                        if (in_valid) begin
                            frame_d = in_data;
                        end else begin
                            frame_d    = '0;
                            underrun_d = 1'b1;
                            if (ucnt_q != 16'hFFFF) begin
                                ucnt_d = ucnt_q + 16'd1;
                            end
                        end
                    end else begin
                        state_d = StIdle;
                        frame_d = '0;
                        delay_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge sclk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            frame_q    <= '0;
            mode_q     <= 1'b0;
            delay_q    <= '0;
            underrun_q <= 1'b0;
            ucnt_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            mode_q     <= mode_d;
            delay_q    <= delay_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    always_comb begin
        lrclk        = (state_q == StIdle) | ch;
        sdata        = (state_q == StRun) ? (mode_q ? lj_bit : delay_q) : '0;
        underrun     = underrun_q;
        underrun_cnt = ucnt_q;
    end

endmodule
